// File: rtl/ram2p_fifo_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ram2p_fifo_ctrl_pkg
//   Shared constants for the two-port-RAM FIFO controller and its output
//   stage: default word width, RAM address width, RAM depth and the width of
//   the fill-level counter (enough for DEPTH words in RAM plus two in the
//   prefetch stage).
// ---------------------------------------------------------------------------
package ram2p_fifo_ctrl_pkg;

  localparam int RAMFIFO_WIDTH  = 16;
  localparam int RAMFIFO_ADDR_W = 8;
  localparam int RAMFIFO_DEPTH  = 256;
  // RAM words (0..DEPTH) + in-flight read + 2-entry output stage
  localparam int RAMFIFO_FILL_W = RAMFIFO_ADDR_W + 2;

endpackage

// File: rtl/ramfifo_out_stage.sv
// ---------------------------------------------------------------------------
// ramfifo_out_stage
//   Two-entry register FIFO that receives words returning from the RAM read
//   port and presents the head word to the consumer. Capture and pop may occur
//   in the same cycle; order is preserved.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   i_clear      in   synchronous clear of both entries and the count
//   i_capture    in   store i_cap_data this cycle
//   i_cap_data   in   word returning from the RAM
//   i_pop        in   head word consumed this cycle (must only be set when valid)
//   o_valid      out  at least one entry held
//   o_data       out  head entry
//   o_count      out  entries currently held (0..2)
//   o_count_nxt  out  entries held after the coming edge
// ---------------------------------------------------------------------------
module ramfifo_out_stage
  import ram2p_fifo_ctrl_pkg::*;
#(
  parameter int WIDTH = RAMFIFO_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_capture,
  input  logic [WIDTH-1:0] i_cap_data,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic [1:0]       o_count,
  output logic [1:0]       o_count_nxt
);

  logic [WIDTH-1:0] r_entry0;
  logic [WIDTH-1:0] r_entry1;
  logic             r_head;
  logic [1:0]       r_count;
  logic             w_wr_idx;

  // Slot after the current occupants. With two held entries a capture can
  // only happen together with a pop, and then the freed head slot is reused.
  assign w_wr_idx = r_head ^ r_count[0];

  assign o_count_nxt = i_clear ? 2'd0
                     : (r_count + {1'b0, i_capture} - {1'b0, i_pop});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_entry0 <= '0;
      r_entry1 <= '0;
      r_head   <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_clear) begin
      r_entry0 <= '0;
      r_entry1 <= '0;
      r_head   <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_capture) begin
        if (w_wr_idx) r_entry1 <= i_cap_data;
        else          r_entry0 <= i_cap_data;
      end
      if (i_pop) r_head <= ~r_head;
      r_count <= o_count_nxt;
    end
  end

  assign o_valid = (r_count != 2'd0);
  assign o_data  = r_head ? r_entry1 : r_entry0;
  assign o_count = r_count;

endmodule

// File: rtl/ram2p_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// ram2p_fifo_ctrl
//   FIFO controller sequencing an external two-port RAM as a circular buffer.
//   Writes go straight to the RAM; reads are prefetched into a 2-entry output
//   stage so the RAM's one-cycle read latency is hidden and both sides see
//   first-word-fall-through valid/ready streams.
//
// Optional build macro
//   RAMFIFO_WATERMARK_EN : adds output highWater, the largest fillLevel seen
//                          since reset or the last flush.
//
// Ports
//   clockCore        in   core clock, rising edge
//   resetCoreN       in   asynchronous active-low reset
//   flush            in   synchronous clear of all contents
//   pushValid/Ready  in/out  producer handshake, pushData in
//   popValid/Ready   out/in  consumer handshake, popData out (head word)
//   fillLevel        out  registered words held (RAM + in flight + output stage)
//   highWater        out  (RAMFIFO_WATERMARK_EN only) peak fillLevel
//   ramEnableWrite, ramAddressWrite, ramWriteData   out  RAM write port
//   ramEnableRead, ramAddressRead                   out  RAM read port
//   ramReadData      in   RAM read data, valid the cycle after ramEnableRead
// ---------------------------------------------------------------------------
module ram2p_fifo_ctrl
  import ram2p_fifo_ctrl_pkg::*;
#(
  parameter int WIDTH  = RAMFIFO_WIDTH,
  parameter int ADDR_W = RAMFIFO_ADDR_W,
  parameter int DEPTH  = RAMFIFO_DEPTH
) (
  input  logic              clockCore,
  input  logic              resetCoreN,
  input  logic              flush,
  input  logic              pushValid,
  output logic              pushReady,
  input  logic [WIDTH-1:0]  pushData,
  output logic              popValid,
  input  logic              popReady,
  output logic [WIDTH-1:0]  popData,
  output logic [ADDR_W+1:0] fillLevel,
`ifdef RAMFIFO_WATERMARK_EN
  output logic [ADDR_W+1:0] highWater,
`endif
  output logic              ramEnableWrite,
  output logic [ADDR_W-1:0] ramAddressWrite,
  output logic [WIDTH-1:0]  ramWriteData,
  output logic              ramEnableRead,
  output logic [ADDR_W-1:0] ramAddressRead,
  input  logic [WIDTH-1:0]  ramReadData
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_ram_count;
  logic              r_inflight;
  logic [ADDR_W+1:0] r_fill;

  logic              w_push_ready;
  logic              w_push_fire;
  logic              w_pop_valid;
  logic              w_pop_fire;
  logic              w_read_issue;
  logic              w_capture;
  logic [1:0]        w_out_count;
  logic [1:0]        w_out_count_nxt;
  logic [ADDR_W:0]   w_ram_count_nxt;
  logic [ADDR_W+1:0] w_fill_nxt;
  logic [WIDTH-1:0]  w_pop_data;

  // Gating with resetCoreN keeps pushReady low while reset is held and lets
  // it rise as soon as reset is released.
  assign w_push_ready = resetCoreN & ~flush & (r_ram_count < DEPTH_C);
  assign w_push_fire  = pushValid & w_push_ready;
  assign w_pop_fire   = w_pop_valid & popReady;

  // Issue a read only if the output stage will have room when the word
  // returns: held + in flight - leaving this cycle < 2.
  assign w_read_issue = (r_ram_count != '0) & ~flush &
                        (({1'b0, w_out_count} + {2'b00, r_inflight}) <
                         (3'd2 + {2'b00, w_pop_fire}));

  // A word returning during flush is dropped.
  assign w_capture = r_inflight & ~flush;

  assign w_ram_count_nxt = flush ? '0
                         : (r_ram_count + {{ADDR_W{1'b0}}, w_push_fire}
                                        - {{ADDR_W{1'b0}}, w_read_issue});

  assign w_fill_nxt = {1'b0, w_ram_count_nxt}
                    + {{(ADDR_W+1){1'b0}}, w_read_issue}
                    + {{ADDR_W{1'b0}}, w_out_count_nxt};

  always_ff @(posedge clockCore or negedge resetCoreN) begin
    if (!resetCoreN) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_ram_count <= '0;
      r_inflight  <= 1'b0;
      r_fill      <= '0;
    end else if (flush) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_ram_count <= '0;
      r_inflight  <= 1'b0;
      r_fill      <= '0;
    end else begin
      // Pointers wrap naturally; full/empty come from r_ram_count only.
      if (w_push_fire)  r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      if (w_read_issue) r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      r_ram_count <= w_ram_count_nxt;
      r_inflight  <= w_read_issue;
      r_fill      <= w_fill_nxt;
    end
  end

  ramfifo_out_stage #(
    .WIDTH (WIDTH)
  ) u_out_stage (
    .clk         (clockCore),
    .rst_n       (resetCoreN),
    .i_clear     (flush),
    .i_capture   (w_capture),
    .i_cap_data  (ramReadData),
    .i_pop       (w_pop_fire),
    .o_valid     (w_pop_valid),
    .o_data      (w_pop_data),
    .o_count     (w_out_count),
    .o_count_nxt (w_out_count_nxt)
  );

`ifdef RAMFIFO_WATERMARK_EN
  logic [ADDR_W+1:0] r_high_water;

  always_ff @(posedge clockCore or negedge resetCoreN) begin
    if (!resetCoreN) begin
      r_high_water <= '0;
    end else if (flush) begin
      r_high_water <= '0;
    end else if (r_fill > r_high_water) begin
      r_high_water <= r_fill;
    end
  end

  assign highWater = r_high_water;
`endif

  assign pushReady       = w_push_ready;
  assign popValid        = w_pop_valid;
  assign popData         = w_pop_data;
  assign fillLevel       = r_fill;

  assign ramEnableWrite  = w_push_fire;
  assign ramAddressWrite = r_wr_ptr;
  assign ramWriteData    = w_push_fire ? pushData : '0;
  assign ramEnableRead   = w_read_issue;
  assign ramAddressRead  = r_rd_ptr;

endmodule

// File: tb/tb_ram2p_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ram2p_fifo_ctrl
//   Directed bench for ram2p_fifo_ctrl with a behavioural two-port RAM beside
//   it. Accepted pushes are queued as expected words and compared when the
//   controller pops them; fillLevel is compared with the queue depth.
// ---------------------------------------------------------------------------
module tb_ram2p_fifo_ctrl;
  import ram2p_fifo_ctrl_pkg::*;

  localparam int W  = RAMFIFO_WIDTH;
  localparam int AW = RAMFIFO_ADDR_W;
  localparam int FW = RAMFIFO_FILL_W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          push_valid;
  logic          push_ready;
  logic [W-1:0]  push_data;
  logic          pop_valid;
  logic          pop_ready;
  logic [W-1:0]  pop_data;
  logic [FW-1:0] fill_level;
`ifdef RAMFIFO_WATERMARK_EN
  logic [FW-1:0] high_water;
`endif
  logic          ram_en_w;
  logic [AW-1:0] ram_addr_w;
  logic [W-1:0]  ram_wdata;
  logic          ram_en_r;
  logic [AW-1:0] ram_addr_r;
  logic [W-1:0]  ram_rdata;

  always #5 clk = ~clk;

  ram2p_fifo_ctrl dut (
    .clockCore       (clk),
    .resetCoreN      (rst_n),
    .flush           (flush),
    .pushValid       (push_valid),
    .pushReady       (push_ready),
    .pushData        (push_data),
    .popValid        (pop_valid),
    .popReady        (pop_ready),
    .popData         (pop_data),
    .fillLevel       (fill_level),
`ifdef RAMFIFO_WATERMARK_EN
    .highWater       (high_water),
`endif
    .ramEnableWrite  (ram_en_w),
    .ramAddressWrite (ram_addr_w),
    .ramWriteData    (ram_wdata),
    .ramEnableRead   (ram_en_r),
    .ramAddressRead  (ram_addr_r),
    .ramReadData     (ram_rdata)
  );

  // Behavioural two-port RAM, one-cycle read latency
  logic [W-1:0] mem [2**AW];
  always @(posedge clk) begin
    if (ram_en_w) mem[ram_addr_w] <= ram_wdata;
    if (ram_en_r) ram_rdata <= mem[ram_addr_r];
  end

  int           n_assert = 0;
  int           n_fail   = 0;
  logic [W-1:0] sb[$];
  logic [AW-1:0] exp_waddr = '0;
  logic [AW-1:0] exp_raddr = '0;
  logic         last_push_fire;
  logic         last_pop_fire;
  int           max_fill = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sample on the falling edge and update the scoreboard for this cycle.
  task automatic sample();
    @(negedge clk);
    last_push_fire = 1'b0;
    last_pop_fire  = 1'b0;
    check("fill_vs_model", 32'(fill_level), 32'(sb.size()));
    if (int'(fill_level) > max_fill) max_fill = int'(fill_level);
    if (flush) begin
      check("flush_push_ready", 32'(push_ready), 32'd0);
      check("flush_wr_en", 32'(ram_en_w), 32'd0);
      check("flush_rd_en", 32'(ram_en_r), 32'd0);
      sb.delete();
      exp_waddr = '0;
      exp_raddr = '0;
    end else begin
      if (push_valid && push_ready) begin
        check("wr_en", 32'(ram_en_w), 32'd1);
        check("wr_addr", 32'(ram_addr_w), 32'(exp_waddr));
        check("wr_data", 32'(ram_wdata), 32'(push_data));
        sb.push_back(push_data);
        exp_waddr = exp_waddr + 1'b1;
        last_push_fire = 1'b1;
      end else begin
        check("wr_idle", 32'(ram_en_w), 32'd0);
      end
      if (ram_en_r) begin
        check("rd_addr", 32'(ram_addr_r), 32'(exp_raddr));
        exp_raddr = exp_raddr + 1'b1;
      end
      if (pop_valid && pop_ready) begin
        check("pop_sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) check("pop_data", 32'(pop_data), 32'(sb.pop_front()));
        last_pop_fire = 1'b1;
      end
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    sample();
    adv();
  endtask

  task automatic drain(input string tag);
    push_valid = 1'b0;
    pop_ready  = 1'b1;
    for (int g = 0; g < 400 && (sb.size() > 0 || pop_valid); g++) step();
    step();
    check(tag, 32'(sb.size()), 32'd0);
    sample();
    check({tag, "_popvalid"}, 32'(pop_valid), 32'd0);
    check({tag, "_fill"}, 32'(fill_level), 32'd0);
    adv();
  endtask

  initial begin
    int n;
    int nxt;
    int guard;
    int stalls;
    int first_pop;
    int last_pop;
    int npop;
    int rst_at;

    // ---------------- reset state ----------------
    rst_n = 1'b0; flush = 1'b0; push_valid = 1'b1; push_data = 16'h5555; pop_ready = 1'b1;
    #2;
    check("rst_push_ready", 32'(push_ready), 32'd0);
    check("rst_pop_valid", 32'(pop_valid), 32'd0);
    check("rst_pop_data", 32'(pop_data), 32'd0);
    check("rst_wr_en", 32'(ram_en_w), 32'd0);
    check("rst_rd_en", 32'(ram_en_r), 32'd0);
    check("rst_wr_addr", 32'(ram_addr_w), 32'd0);
    check("rst_rd_addr", 32'(ram_addr_r), 32'd0);
    check("rst_wr_data", 32'(ram_wdata), 32'd0);
    check("rst_fill", 32'(fill_level), 32'd0);
`ifdef RAMFIFO_WATERMARK_EN
    check("rst_high_water", 32'(high_water), 32'd0);
`endif
    @(posedge clk); @(posedge clk); #1;
    check("rst_hold_pop_valid", 32'(pop_valid), 32'd0);
    push_valid = 1'b0; pop_ready = 1'b0;
    #2 rst_n = 1'b1;
    #1;
    check("rel_push_ready", 32'(push_ready), 32'd1);
    check("rel_fill", 32'(fill_level), 32'd0);
    adv();

    // ---------------- single word latency ----------------
    push_valid = 1'b1; push_data = 16'h1234;
    sample();
    check("sw_c0_wr_en", 32'(ram_en_w), 32'd1);
    check("sw_c0_wr_addr", 32'(ram_addr_w), 32'd0);
    check("sw_c0_wr_data", 32'(ram_wdata), 32'h1234);
    check("sw_c0_rd_en", 32'(ram_en_r), 32'd0);
    adv();
    push_valid = 1'b0;
    sample();
    check("sw_c1_rd_en", 32'(ram_en_r), 32'd1);
    check("sw_c1_rd_addr", 32'(ram_addr_r), 32'd0);
    check("sw_c1_fill", 32'(fill_level), 32'd1);
    adv();
    sample();
    check("sw_c2_pop_valid", 32'(pop_valid), 32'd0);
    adv();
    sample();
    check("sw_c3_pop_valid", 32'(pop_valid), 32'd1);
    check("sw_c3_pop_data", 32'(pop_data), 32'h1234);
    check("sw_c3_fill", 32'(fill_level), 32'd1);
    adv();
    pop_ready = 1'b1;
    step();
    pop_ready = 1'b0;
    sample();
    check("sw_after_pop_fill", 32'(fill_level), 32'd0);
    check("sw_after_pop_valid", 32'(pop_valid), 32'd0);
    adv();

    // ---------------- fill to capacity ----------------
    pop_ready = 1'b0; push_valid = 1'b1; n = 0;
    for (int i = 0; i < 258; i++) begin
      push_data = 16'h0100 + 16'(i);
      step();
      if (last_push_fire) n++;
    end
    check("full_accepts", 32'(n), 32'd258);
    push_data = 16'hFFFF;
    sample();
    check("full_push_ready", 32'(push_ready), 32'd0);
    check("full_fill", 32'(fill_level), 32'd258);
    check("full_rd_idle", 32'(ram_en_r), 32'd0);
    check("full_pop_valid", 32'(pop_valid), 32'd1);
    adv();
    sample();
    check("full_rd_idle2", 32'(ram_en_r), 32'd0);
    adv();
    drain("full_drain");

    // ---------------- wrap and stream ----------------
    push_valid = 1'b1; pop_ready = 1'b1;
    stalls = 0; first_pop = -1; last_pop = -1; npop = 0;
    for (int c = 0; c < 1003; c++) begin
      push_valid = (c < 1000);
      push_data  = 16'(c);
      step();
      if (push_valid && !last_push_fire) stalls++;
      if (last_pop_fire) begin
        if (first_pop < 0) first_pop = c;
        last_pop = c;
        npop++;
      end
    end
    check("stream_stalls", 32'(stalls), 32'd0);
    check("stream_first_pop", 32'(first_pop), 32'd3);
    check("stream_pop_count", 32'(npop), 32'd1000);
    check("stream_no_gaps", 32'(last_pop - first_pop + 1), 32'd1000);
    drain("stream_drain");

    // ---------------- random backpressure ----------------
    nxt = 0; guard = 0;
    while (nxt < 600 && guard < 5000) begin
      push_valid = 1'b1;
      push_data  = 16'h4000 + 16'(nxt);
      pop_ready  = 1'($urandom_range(0, 1));
      step();
      if (last_push_fire) nxt++;
      guard++;
    end
    check("bp_all_pushed", 32'(nxt), 32'd600);
    drain("bp_drain");
    check("max_fill_le_258", 32'(max_fill <= 258), 32'd1);

    // ---------------- flush with a read in flight ----------------
    pop_ready = 1'b0; push_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push_data = 16'hA000 + 16'(i);
      step();
    end
    push_valid = 1'b0;
    step(); step();
`ifdef RAMFIFO_WATERMARK_EN
    check("hw_before_flush", 32'(high_water), 32'(max_fill));
`endif
    pop_ready = 1'b1;
    sample();
    check("fl_read_issued", 32'(ram_en_r), 32'd1);
    adv();
    pop_ready = 1'b1; flush = 1'b1; push_valid = 1'b1; push_data = 16'hDEAD;
    step();
    flush = 1'b0; push_valid = 1'b0; pop_ready = 1'b0;
    sample();
    check("fl_pop_valid", 32'(pop_valid), 32'd0);
    check("fl_fill", 32'(fill_level), 32'd0);
`ifdef RAMFIFO_WATERMARK_EN
    check("fl_high_water", 32'(high_water), 32'd0);
`endif
    adv();
    push_valid = 1'b1; push_data = 16'hBEEF;
    sample();
    check("fl_beef_wr_addr", 32'(ram_addr_w), 32'd0);
    adv();
    push_valid = 1'b0;
    step(); step();
    sample();
    check("fl_beef_valid", 32'(pop_valid), 32'd1);
    check("fl_beef_data", 32'(pop_data), 32'hBEEF);
    adv();
    drain("fl_drain");

    // ---------------- async reset mid-stream ----------------
    rst_at = $urandom_range(20, 60);
    nxt = 0;
    push_valid = 1'b1;
    for (int k = 0; k < rst_at; k++) begin
      push_data = 16'h7000 + 16'(nxt);
      pop_ready = 1'($urandom_range(0, 1));
      step();
      if (last_push_fire) nxt++;
    end
    pop_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("ar_pop_valid", 32'(pop_valid), 32'd0);
    check("ar_pop_data", 32'(pop_data), 32'd0);
    check("ar_wr_en", 32'(ram_en_w), 32'd0);
    check("ar_rd_en", 32'(ram_en_r), 32'd0);
    check("ar_push_ready", 32'(push_ready), 32'd0);
    check("ar_fill", 32'(fill_level), 32'd0);
    sb.delete();
    exp_waddr = '0;
    exp_raddr = '0;
    @(posedge clk); @(posedge clk); #1;
    push_valid = 1'b0;
    #2 rst_n = 1'b1;
    #1;
    check("ar_rel_push_ready", 32'(push_ready), 32'd1);
    check("ar_rel_fill", 32'(fill_level), 32'd0);
    adv();
    push_valid = 1'b1; push_data = 16'h00C3; pop_ready = 1'b1;
    step();
    push_valid = 1'b0;
    drain("ar_post_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ram2p_fifo_ctrl.md
Name: ram2p_fifo_ctrl

Overview:
- Synchronous FIFO controller that sequences a two-port RAM (256x16 default) as a circular buffer.
- Generates write/read addresses and enables for the RAM.
- Hides the RAM's 1-cycle read latency behind a 2-entry prefetch output stage, presenting first-word-fall-through valid/ready streams on both sides.
- Sits between the DMA descriptor/data producers and consumers.

Parameters:
- WIDTH, 16, data word width; must equal the RAM data width.
- ADDR_W, 8, RAM address width.
- DEPTH, 256, RAM entries; must equal 2**ADDR_W.

Ports:
- clockCore  in  1  core clock; all logic is rising-edge.
- resetCoreN  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of all contents.
- pushValid  in  1  producer has a word.
- pushReady  out  1  controller accepts the word this cycle.
- pushData  in  WIDTH  producer word.
- popValid  out  1  popData is valid.
- popReady  in  1  consumer takes the word this cycle.
- popData  out  WIDTH  head word.
- fillLevel  out  ADDR_W+2  words held in RAM + in flight + output stage (max DEPTH+2).
- ramEnableWrite  out  1  RAM write enable.
- ramAddressWrite  out  ADDR_W  RAM write address.
- ramWriteData  out  WIDTH  RAM write data.
- ramEnableRead  out  1  RAM read enable.
- ramAddressRead  out  ADDR_W  RAM read address.
- ramReadData  in  WIDTH  RAM read data; valid the cycle after ramEnableRead.

Behaviour:
- Reset (async assert, sync-released by the system):
  - wrPtr, rdPtr, ramCount, inflight, outCount, fillLevel all 0.
  - pushReady 0 during reset, 1 the first cycle after.
  - popValid 0; popData 0; all ram* outputs 0.
- Push:
  - pushReady = (ramCount < DEPTH) & ~flush.
  - On pushValid & pushReady: ramEnableWrite=1, ramAddressWrite=wrPtr, ramWriteData=pushData (combinational pass-through); wrPtr increments mod DEPTH.
- Prefetch:
  - ramEnableRead=1 when ramCount>0 & (outCount + inflight - popFire) < 2 & ~flush; ramAddressRead=rdPtr; rdPtr increments mod DEPTH.
  - inflight is a 1-bit register set by ramEnableRead.
  - The cycle after a read, ramReadData is written into the output stage.
- ramCount next = ramCount + pushFire - readIssue.
  - Simultaneous push and read-issue leaves it unchanged.
  - No same-address hazard: reads target only already-written entries.
- Output stage: 2-entry register FIFO (head/tail).
  - popValid = outCount>0; popData = head entry.
  - popFire = popValid & popReady.
  - Capture and pop in the same cycle are legal; order is preserved.
- Latency: empty FIFO, push in cycle 0 -> read issued cycle 1 -> data captured end of cycle 2 -> popValid=1 in cycle 3.
- Throughput: one push and one pop per cycle sustained.
- Full: ramCount=DEPTH drops pushReady; total capacity is DEPTH+2 words.
- Empty: ramCount=0 and outCount=0 gives popValid=0. popReady while empty is ignored.
- fillLevel is registered and equals ramCount + inflight + outCount after each edge.
- Flush:
  - Next edge clears pointers, counts, inflight and output stage.
  - Any read in flight is discarded.
  - pushReady=0 and no RAM enables while flush=1.
  - A push or pop presented during flush is not performed.
- Reset mid-operation: all state returns to reset values immediately; RAM contents are don't-care.
- Pointer wrap: pointers are ADDR_W bits, wrap 255->0 naturally; full/empty are decided by ramCount, never by pointer compare.

Optional Feature:
- RAMFIFO_WATERMARK_EN
  - Defined: adds output highWater (ADDR_W+2 bits, reset 0) that holds the maximum fillLevel seen since reset or the last flush. It updates the cycle after fillLevel exceeds it; flush clears it to 0.
  - Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package: RAMFIFO_WIDTH=16, RAMFIFO_ADDR_W=8, RAMFIFO_DEPTH=256, and the fill-level width constant (ADDR_W+2).
- One natural sub-module: ramfifo_out_stage (2-entry prefetch register FIFO with capture/pop/clear).
- The controller instantiates ramfifo_out_stage; the RAM wrapper is instantiated beside it at the next level up.

Test Plan:
- Single word: push 0x1234 at cycle 0 -> ramEnableWrite with addr 0 cycle 0, ramEnableRead addr 0 cycle 1, popValid=1 with popData=0x1234 cycle 3, fillLevel 1 then 0 after pop.
- Fill: push 258 words with popReady=0 -> pushReady=0 after the 258th accept, fillLevel=258, ramCount=256, no RAM read after the output stage fills.
- Wrap and stream: 1000 sequential words (0..999) with pushValid=popReady=1 -> output in order without gaps after the initial 3-cycle latency, addresses wrap 255->0.
- Backpressure: random popReady (50%) against continuous push of 600 incrementing words -> no loss or duplication; fillLevel never exceeds 258.
- Flush mid-flight: fill 10 words, assert flush in the cycle a read is issued -> next cycle popValid=0, fillLevel=0, highWater=0 (if enabled); push 0xBEEF -> appears at popData 3 cycles later.
- Async reset mid-stream: drop resetCoreN at a random cycle -> popValid and RAM enables go 0 immediately; after release, fillLevel=0 and pushReady=1.
